// File: rtl/div_seq_if.sv
// Handshake bundle for the sequential FP divider: an operand channel
// (a, b, rnd) and a result channel (res), each with its own valid/ready pair.
interface div_seq_if #(
  parameter int W = 32
) ();
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   rnd;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] res;

  // Issuer side: drives operands and accepts results.
  modport master (
    output in_valid, a, b, rnd, out_ready,
    input  in_ready, out_valid, res
  );

  // Divider side.
  modport slave (
    input  in_valid, a, b, rnd, out_ready,
    output in_ready, out_valid, res
  );
endinterface

// File: rtl/div_seq.sv
// Sequential binary32 divider (res = a / b) using radix-2 restoring division.
// One quotient bit per cycle, full subnormal support, four rounding modes,
// one operation in flight, valid/ready on both the operand and result sides.
module div_seq #(
  parameter int SIGN_W = 1,
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23
) (
  input  logic       clk,
  input  logic       rst,
  div_seq_if.slave   bus
);
  localparam int W    = SIGN_W + EXPO_W + MANT_W;
  localparam int MW   = MANT_W + 1;          // significand incl. hidden bit
  localparam int QW   = MANT_W + 3;          // quotient bits == remainder width
  localparam int EW   = EXPO_W + 2;          // signed working exponent
  localparam int CW   = $clog2(QW);
  localparam int BIAS = 2**(EXPO_W-1) - 1;
  localparam int EMAX = 2**EXPO_W - 1;
  localparam logic signed [EW-1:0] BIAS_E    = EW'(BIAS);
  localparam logic [W-1:0]         QNAN_BIT  = W'(1) << (MANT_W-1);
  localparam logic [W-1:0]         CANON_NAN = {1'b0, {EXPO_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, PREP, ITER, ROUND, DONE} state_t;

  state_t                 state;
  logic [W-1:0]           a_q, b_q, res_q;
  logic [1:0]             rnd_q;
  logic                   sign_q, out_valid_q;
  logic signed [EW-1:0]   exp_q;
  logic [QW-1:0]          rem_q, quo_q;
  logic [MW-1:0]          div_q;
  logic [CW-1:0]          cnt_q;

  // Leading-zero count of a significand; MW when the input is zero.
  function automatic int lzc(input logic [MW-1:0] v);
    int n;
    n = MW;
    for (int i = 0; i < MW; i++) if (v[i]) n = MW - 1 - i;
    return n;
  endfunction

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.res       = res_q;

  // Operand classification, subnormal normalisation and special-case results.
  logic [EXPO_W-1:0]    a_exp, b_exp;
  logic [MANT_W-1:0]    a_frac, b_frac;
  logic                 a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, sign_c;
  logic [MW-1:0]        ma_raw, mb_raw, ma_n, mb_n;
  logic signed [EW-1:0] ea, eb, e_pre;
  logic                 special;
  logic [W-1:0]         special_res;
  int                   la, lb;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    special     = 1'b0;
    special_res = '0;
    a_exp  = a_q[MANT_W +: EXPO_W];
    b_exp  = b_q[MANT_W +: EXPO_W];
    a_frac = a_q[MANT_W-1:0];
    b_frac = b_q[MANT_W-1:0];
    sign_c = a_q[W-1] ^ b_q[W-1];
    a_zero = (a_exp == '0) && (a_frac == '0);
    b_zero = (b_exp == '0) && (b_frac == '0);
    a_inf  = (a_exp == '1) && (a_frac == '0);
    b_inf  = (b_exp == '1) && (b_frac == '0);
    a_nan  = (a_exp == '1) && (a_frac != '0);
    b_nan  = (b_exp == '1) && (b_frac != '0);
    ma_raw = {a_exp != '0, a_frac};
    mb_raw = {b_exp != '0, b_frac};
    la     = lzc(ma_raw);
    lb     = lzc(mb_raw);
    ma_n   = ma_raw << la;
    mb_n   = mb_raw << lb;
    ea     = (a_exp == '0) ? EW'(1 - la) : EW'(a_exp);
    eb     = (b_exp == '0) ? EW'(1 - lb) : EW'(b_exp);
    e_pre  = ea - eb + BIAS_E;
    if (a_nan || b_nan) begin
      special     = 1'b1;
      special_res = (a_nan ? a_q : b_q) | QNAN_BIT;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      special     = 1'b1;
      special_res = CANON_NAN;
    end else if (a_inf || b_zero) begin
      special     = 1'b1;
      special_res = {sign_c, {EXPO_W{1'b1}}, {MANT_W{1'b0}}};
    end else if (a_zero || b_inf) begin
      special     = 1'b1;
      special_res = {sign_c, {(W-1){1'b0}}};
    end
  end

  // One restoring-division step: subtract the divisor if it fits.
  logic [QW:0]   trial;
  logic          qbit;
  logic [QW-1:0] rem_nxt;

  always_comb begin
    trial   = {1'b0, rem_q} - {{(QW+1-MW){1'b0}}, div_q};
    qbit    = !trial[QW];
    rem_nxt = qbit ? trial[QW-1:0] : rem_q;
  end

  // Normalise, denormalise on underflow, round, and saturate on overflow.
  logic [QW-1:0]              n;
  logic signed [EW-1:0]       e_n;
  logic                       st, carry;
  logic [EXPO_W-1:0]          e_field;
  logic [EXPO_W+MANT_W-1:0]   sum;
  logic [W-1:0]               round_res;
  int                         sh;

  always_comb begin
    n     = quo_q[QW-1] ? quo_q : {quo_q[QW-2:0], 1'b0};
    e_n   = quo_q[QW-1] ? exp_q : exp_q - EW'(1);
    st    = (rem_q != '0);
    sh    = 0;
    carry = 1'b0;
    if (e_n < 1) begin
      sh = 1 - int'(e_n);
      if (sh > QW-1) sh = QW-1;
      for (int i = 0; i < QW; i++) if (i < sh) st = st | n[i];
      n = n >> sh;
    end
    // The hidden bit survives only for normal results, so it selects the field.
    e_field = n[QW-1] ? e_n[EXPO_W-1:0] : '0;
    case (rnd_q)
      2'b11:   carry = n[1] && (n[2] || n[0] || st);
      2'b10:   carry = !sign_q && (n[1] || n[0] || st);
      2'b01:   carry = sign_q && (n[1] || n[0] || st);
      default: carry = 1'b0;
    endcase
    // A mantissa carry-out ripples into the exponent field.
    sum = {e_field, n[QW-2:2]} + {{(EXPO_W+MANT_W-1){1'b0}}, carry};
    if (e_n >= EMAX) begin
      if ((rnd_q[1] && !sign_q) || (rnd_q[0] && sign_q))
        round_res = {sign_q, {EXPO_W{1'b1}}, {MANT_W{1'b0}}};
      else
        round_res = {sign_q, EXPO_W'(EMAX-1), {MANT_W{1'b1}}};
    end else begin
      round_res = {sign_q, sum};
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every register samples pre-edge values.
    if (rst) begin
      // NOTE: all registers are flops (no RAM arrays), so clearing them in reset is free of side effects.
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      rnd_q       <= '0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          a_q   <= bus.a;
          b_q   <= bus.b;
          rnd_q <= bus.rnd;
          state <= PREP;
        end
        PREP: begin
          sign_q <= sign_c;
          if (special) begin
            res_q       <= special_res;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            exp_q <= e_pre;
            rem_q <= QW'(ma_n);
            div_q <= mb_n;
            quo_q <= '0;
            cnt_q <= '0;
            state <= ITER;
          end
        end
        ITER: begin
          rem_q <= rem_nxt << 1;
          quo_q <= {quo_q[QW-2:0], qbit};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(QW-1)) state <= ROUND;
        end
        ROUND: begin
          res_q       <= round_res;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: scoreboard of expected results and latencies,
// checked with immediate assertions when the divider presents each result.
module tb_div_seq;
  logic clk = 1'b0;
  logic rst;

  div_seq_if #(.W(32)) bus ();

  div_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  localparam int NORM = 29;
  localparam int SPEC = 2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic expect_res(input string tag, input logic [31:0] res, input int lat);
    exp_t e;
    e.tag = tag;
    e.res = res;
    e.lat = lat;
    sb.push_back(e);
  endtask

  // Drive one operation at a negedge; returns on the negedge after acceptance.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rnd);
    int t = 0;
    while (bus.in_ready !== 1'b1 && t < 60) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_before_send", bus.in_ready, 1'b1);
    bus.a        = a;
    bus.b        = b;
    bus.rnd      = rnd;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Wait for a result, compare against the scoreboard, optionally stall, then accept.
  task automatic receive(input int hold, input bit early);
    int   cnt     = 1;
    bit   busy_ok = 1'b1;
    exp_t e;
    if (early) bus.out_ready = 1'b1;
    while (bus.out_valid !== 1'b1 && cnt < 60) begin
      if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
      @(negedge clk);
      cnt++;
    end
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      bus.out_ready = 1'b0;
      return;
    end
    e = sb.pop_front();
    check({e.tag, "_valid"},   bus.out_valid, 1'b1);
    check({e.tag, "_res"},     bus.res, e.res);
    check({e.tag, "_latency"}, cnt, e.lat);
    check({e.tag, "_busy"},    busy_ok, 1'b1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({e.tag, "_hold_valid"},    bus.out_valid, 1'b1);
      check({e.tag, "_hold_res"},      bus.res, e.res);
      check({e.tag, "_hold_in_ready"}, bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({e.tag, "_valid_drop"}, bus.out_valid, 1'b0);
    check({e.tag, "_ready_back"}, bus.in_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a         = 32'h40400000;
    bus.b         = 32'h40000000;
    bus.rnd       = 2'b11;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_res",       bus.res, 32'h0);
    check("reset_in_ready",  bus.in_ready, 1'b0);
    bus.in_valid = 1'b0;
    rst          = 1'b0;
    #1;
    check("post_reset_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    check("post_reset_idle", bus.out_valid, 1'b0);

    // Basic quotient and latency.
    expect_res("div_3_2", 32'h3FC00000, NORM);
    send(32'h40400000, 32'h40000000, 2'b11); receive(0, 1'b0);

    // 1/3 under each rounding mode.
    expect_res("third_rne", 32'h3EAAAAAB, NORM);
    send(32'h3F800000, 32'h40400000, 2'b11); receive(0, 1'b0);
    expect_res("third_pinf", 32'h3EAAAAAB, NORM);
    send(32'h3F800000, 32'h40400000, 2'b10); receive(0, 1'b0);
    expect_res("third_ninf", 32'h3EAAAAAA, NORM);
    send(32'h3F800000, 32'h40400000, 2'b01); receive(0, 1'b0);
    expect_res("third_rtz", 32'h3EAAAAAA, NORM);
    send(32'h3F800000, 32'h40400000, 2'b00); receive(0, 1'b0);

    // Special operands; the second one has out_ready raised early.
    expect_res("one_div_zero", 32'h7F800000, SPEC);
    send(32'h3F800000, 32'h00000000, 2'b11); receive(0, 1'b0);
    expect_res("zero_div_zero", 32'h7FC00000, SPEC);
    send(32'h80000000, 32'h00000000, 2'b11); receive(0, 1'b1);
    expect_res("nan_a", 32'hFFC00001, SPEC);
    send(32'hFF800001, 32'h3F800000, 2'b11); receive(0, 1'b0);
    expect_res("inf_div_inf", 32'h7FC00000, SPEC);
    send(32'h7F800000, 32'h7F800000, 2'b11); receive(0, 1'b0);

    // Overflow handling per rounding mode and sign.
    expect_res("ovf_rne", 32'h7F800000, NORM);
    send(32'h7F7FFFFF, 32'h3F000000, 2'b11); receive(0, 1'b0);
    expect_res("ovf_rtz", 32'h7F7FFFFF, NORM);
    send(32'h7F7FFFFF, 32'h3F000000, 2'b00); receive(0, 1'b0);
    expect_res("ovf_ninf_pos", 32'h7F7FFFFF, NORM);
    send(32'h7F7FFFFF, 32'h3F000000, 2'b01); receive(0, 1'b0);
    expect_res("ovf_ninf_neg", 32'hFF800000, NORM);
    send(32'hFF7FFFFF, 32'h3F000000, 2'b01); receive(0, 1'b0);

    // Subnormal results and total underflow.
    expect_res("sub_min_norm_half", 32'h00400000, NORM);
    send(32'h00800000, 32'h40000000, 2'b11); receive(0, 1'b0);
    expect_res("sub_min_times2", 32'h00000002, NORM);
    send(32'h00000001, 32'h3F000000, 2'b11); receive(0, 1'b0);
    expect_res("uflow_rne", 32'h00000000, NORM);
    send(32'h00000001, 32'h40800000, 2'b11); receive(0, 1'b0);
    expect_res("uflow_pinf", 32'h00000001, NORM);
    send(32'h00000001, 32'h40800000, 2'b10); receive(0, 1'b0);

    // Result backpressure for 5 cycles.
    expect_res("backpressure", 32'h3EAAAAAB, NORM);
    send(32'h3F800000, 32'h40400000, 2'b11); receive(5, 1'b0);

    // Reset in the middle of an iteration aborts without output.
    send(32'h3F800000, 32'h40400000, 2'b11);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_out_valid", bus.out_valid, 1'b0);
    check("abort_in_ready_in_rst", bus.in_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("abort_in_ready", bus.in_ready, 1'b1);
    repeat (30) @(negedge clk);
    check("abort_no_output", bus.out_valid, 1'b0);
    expect_res("after_abort", 32'h3FC00000, NORM);
    send(32'h40400000, 32'h40000000, 2'b11); receive(0, 1'b0);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
